// File: rtl/kmeans_seq_ctrl.sv
// Top-level K-means sequencer: header parse, round-robin pixel scatter, iteration control.
// Optional watchdog on engine/divider waits is enabled with KMEANS_WATCHDOG_TIMEOUT_EN.
module kmeans_seq_ctrl #(
   parameter int E        = 4,
   parameter int T        = 16,
   parameter int PIX_W    = 12,
   parameter int MAX_ITER = 32,
   parameter int ITER_W   = 6,
   parameter int TIMEOUT  = 4095
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              newImage,
   input  logic              start,
   input  logic [23:0]       serialIn,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [E-1:0]      eng_en,
   output logic              eng_wr,
   output logic [PIX_W-1:0]  eng_addr,
   output logic              eng_clr,
   output logic              eng_run,
   input  logic [E-1:0]      eng_done,
   output logic              div_start,
   input  logic              div_done,
   output logic              mean_update,
   input  logic              all_mean_stable,
   output logic [T-1:0]      k_mask,
   output logic [ITER_W-1:0] iter_cnt,
   output logic              busy,
   output logic              done,
   output logic              converged,
   output logic              hdr_err,
   output logic              timeout_err
);

   localparam int LOG2E = (E > 1) ? $clog2(E) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_HDR, S_STORE, S_LOADED, S_CLR, S_RUN,
      S_WAIT_ENG, S_DIVIDE, S_UPDATE, S_CHECK, S_STOP
   } state_e;

   state_e             state_q, state_d;
   logic [PIX_W-1:0]   n_q, n_d;
   logic [4:0]         k_q, k_d;
   logic [PIX_W-1:0]   idx_q, idx_d;
   logic [E-1:0]       collect_q, collect_d;
   logic [T-1:0]       k_mask_q, k_mask_d;
   logic [ITER_W-1:0]  iter_q, iter_d;
   logic               converged_q, converged_d;
   logic               hdr_err_q, hdr_err_d;
   logic               div_first_q, div_first_d;
   logic               busy_q, done_q, eng_clr_q, eng_run_q, mean_update_q;

   logic               accept;
   logic [11:0]        hdr_n;
   logic [4:0]         hdr_k;
   logic [6:0]         hdr_pad_unused;

   assign hdr_n          = serialIn[23:12];
   assign hdr_k          = serialIn[4:0];
   assign hdr_pad_unused = serialIn[11:5];
   assign in_ready       = (state_q == S_HDR) || (state_q == S_STORE);
   assign accept         = in_valid && in_ready;

`ifdef KMEANS_WATCHDOG_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0] wd_q, wd_d;
   logic            timeout_err_q, timeout_err_d;
   assign timeout_err = timeout_err_q;
`else
   localparam int unused_timeout = TIMEOUT;
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      k_d         = k_q;
      idx_d       = idx_q;
      collect_d   = collect_q;
      k_mask_d    = k_mask_q;
      iter_d      = iter_q;
      converged_d = converged_q;
      hdr_err_d   = hdr_err_q;
      div_first_d = 1'b0;
      eng_wr      = 1'b0;
      eng_en      = '0;
      eng_addr    = '0;
`ifdef KMEANS_WATCHDOG_TIMEOUT_EN
      timeout_err_d = timeout_err_q;
`endif

      case (state_q)
         S_IDLE, S_LOADED, S_STOP: begin
            // A new image always wins; start only makes sense once pixels are resident.
            if (newImage) begin
               state_d     = S_HDR;
               hdr_err_d   = 1'b0;
               converged_d = 1'b0;
`ifdef KMEANS_WATCHDOG_TIMEOUT_EN
               timeout_err_d = 1'b0;
`endif
            end else if (start && (state_q != S_IDLE)) begin
               state_d     = S_CLR;
               iter_d      = '0;
               converged_d = 1'b0;
`ifdef KMEANS_WATCHDOG_TIMEOUT_EN
               timeout_err_d = 1'b0;
`endif
            end
         end
         S_HDR: begin
            if (accept) begin
               n_d = PIX_W'(hdr_n);
               k_d = hdr_k;
               if ((hdr_n == '0) || (hdr_k == '0) || ({27'd0, hdr_k} > 32'(T))) begin
                  hdr_err_d = 1'b1;
                  k_mask_d  = '0;
                  state_d   = S_IDLE;
               end else begin
                  for (int j = 0; j < T; j++) begin
                     k_mask_d[j] = (32'(j) < {27'd0, hdr_k});
                  end
                  idx_d   = '0;
                  state_d = S_STORE;
               end
            end
         end
         S_STORE: begin
            if (accept) begin
               eng_wr   = 1'b1;
               eng_en   = E'(1) << idx_q[LOG2E-1:0];
               eng_addr = idx_q >> LOG2E;
               idx_d    = idx_q + 1'b1;
               if (idx_q == (n_q - 1'b1)) begin
                  state_d = S_LOADED;
               end
            end
         end
         S_CLR: state_d = S_RUN;
         S_RUN: begin
            collect_d = '0;
            state_d   = S_WAIT_ENG;
         end
         S_WAIT_ENG: begin
            collect_d = collect_q | eng_done;
            if (&collect_d) begin
               state_d     = S_DIVIDE;
               div_first_d = 1'b1;
            end
         end
         S_DIVIDE: begin
            if (div_done) begin
               state_d = S_UPDATE;
            end
         end
         S_UPDATE: state_d = S_CHECK;
         S_CHECK: begin
            iter_d = iter_q + 1'b1;
            if (all_mean_stable) begin
               state_d     = S_STOP;
               converged_d = 1'b1;
            end else if (iter_d == ITER_W'(MAX_ITER)) begin
               state_d     = S_STOP;
               converged_d = 1'b0;
            end else begin
               state_d = S_CLR;
            end
         end
         default: state_d = S_IDLE;
      endcase

`ifdef KMEANS_WATCHDOG_TIMEOUT_EN
      // Only fires while stuck; a completion on the same cycle takes precedence.
      if (((state_q == S_WAIT_ENG) || (state_q == S_DIVIDE)) && (state_d == state_q) &&
          (wd_q == WD_W'(TIMEOUT - 1))) begin
         state_d       = S_STOP;
         converged_d   = 1'b0;
         timeout_err_d = 1'b1;
      end
`endif
   end

`ifdef KMEANS_WATCHDOG_TIMEOUT_EN
   always_comb begin
      wd_d = '0;
      if (((state_q == S_WAIT_ENG) || (state_q == S_DIVIDE)) && (state_d == state_q)) begin
         wd_d = wd_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wd_q          <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         wd_q          <= wd_d;
         timeout_err_q <= timeout_err_d;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         n_q           <= '0;
         k_q           <= '0;
         idx_q         <= '0;
         collect_q     <= '0;
         k_mask_q      <= '0;
         iter_q        <= '0;
         converged_q   <= 1'b0;
         hdr_err_q     <= 1'b0;
         div_first_q   <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         eng_clr_q     <= 1'b0;
         eng_run_q     <= 1'b0;
         mean_update_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         n_q           <= n_d;
         k_q           <= k_d;
         idx_q         <= idx_d;
         collect_q     <= collect_d;
         k_mask_q      <= k_mask_d;
         iter_q        <= iter_d;
         converged_q   <= converged_d;
         hdr_err_q     <= hdr_err_d;
         div_first_q   <= div_first_d;
         busy_q        <= !((state_d == S_IDLE) || (state_d == S_LOADED) || (state_d == S_STOP));
         done_q        <= (state_d == S_STOP);
         eng_clr_q     <= (state_d == S_CLR);
         eng_run_q     <= (state_d == S_RUN);
         mean_update_q <= (state_d == S_UPDATE);
      end
   end

   assign k_mask      = k_mask_q;
   assign iter_cnt    = iter_q;
   assign converged   = converged_q;
   assign hdr_err     = hdr_err_q;
   assign div_start   = div_first_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign eng_clr     = eng_clr_q;
   assign eng_run     = eng_run_q;
   assign mean_update = mean_update_q;

endmodule

// File: doc/kmeans_seq_ctrl.md
Name: kmeans_seq_ctrl

Overview:
Top-level sequencer for the K-means clustering system. It parses the image header from the serial pixel stream and scatters the pixels round-robin into the E cluster engines. It then runs classify → accumulate → divide → mean-update iterations until the mean file reports all means stable or an iteration cap is hit. It replaces the bare state encoding in the system top with a real controller.

Parameters:
E, 4, number of cluster engines (power of 2)
T, 16, maximum clusters (K)
PIX_W, 12, width of pixel count N
MAX_ITER, 32, iteration cap
ITER_W, 6, iteration counter width (must hold MAX_ITER)
TIMEOUT, 4095, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
newImage  in  1  pulse: header then pixels follow on serialIn
start  in  1  pulse: begin clustering the loaded image
serialIn  in  24  header word {N[23:12], 7'b0, K[4:0]} or RGB pixel
in_valid  in  1  serialIn word valid
in_ready  out  1  word accepted when in_valid & in_ready
eng_en  out  E  one-hot engine select for pixel write
eng_wr  out  1  pixel write strobe
eng_addr  out  PIX_W  per-engine pixel address
eng_clr  out  1  1-cycle clear of engine accumulators/counters
eng_run  out  1  1-cycle start of a classify/accumulate pass
eng_done  in  E  per-engine pass-complete pulse
div_start  out  1  1-cycle start of sum/divide stage
div_done  in  1  divide stage complete pulse
mean_update  out  1  1-cycle strobe to mean file
all_mean_stable  in  1  mean file: no mean changed in last update
k_mask  out  T  bit j set iff cluster j < K is active
iter_cnt  out  ITER_W  completed iterations
busy  out  1  high in any state except IDLE/LOADED/STOP
done  out  1  high in STOP
converged  out  1  valid with done: 1 = stable, 0 = cap hit
hdr_err  out  1  sticky: last header was invalid
timeout_err  out  1  watchdog fired

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; all outputs 0; internal N, K, pixel index, done-collect bits cleared. Reset mid-operation aborts immediately.
- States: IDLE, HDR, STORE, LOADED, CLR, RUN, WAIT_ENG, DIVIDE, UPDATE, CHECK, STOP.
- IDLE/LOADED/STOP + newImage → HDR; clears hdr_err, done, converged. newImage has priority over start when both arrive in the same cycle.
- HDR: in_ready=1. On accept, latch N and K.
  - N==0, K==0 or K>T → hdr_err=1, go to IDLE.
  - Otherwise k_mask=(1<<K)-1, index=0, go to STORE.
- STORE: in_ready=1. Each accepted word drives eng_wr=1 in the same cycle, combinationally.
  - eng_en = one-hot(index mod E); eng_addr = index / E; index++.
  - After the Nth accept → LOADED, in_ready=0.
- LOADED/STOP + start (no newImage) → CLR with iter_cnt=0, done=0. start or newImage in any other state is ignored.
- CLR: eng_clr=1 for 1 cycle → RUN.
- RUN: eng_run=1 for 1 cycle; done-collect bits cleared → WAIT_ENG.
- WAIT_ENG: OR eng_done into sticky collect bits. When all E bits are set (including on the cycle the last pulse arrives) → DIVIDE.
- DIVIDE: div_start=1 on the entry cycle only; wait for div_done → UPDATE. A div_done arriving on the entry cycle is accepted.
- UPDATE: mean_update=1 for 1 cycle → CHECK.
- CHECK: sample all_mean_stable one cycle after mean_update; iter_cnt++.
  - Stable → STOP, converged=1.
  - Else if iter_cnt+1==MAX_ITER → STOP, converged=0.
  - Else → CLR.
- STOP: done=1 held until newImage, start or reset.
- Outputs are registered except eng_wr, eng_en and eng_addr; in_ready is a decode of the state register.

Optional Feature:
KMEANS_WATCHDOG_TIMEOUT_EN
- Defined: a cycle counter runs in WAIT_ENG and DIVIDE and clears on state entry. When it reaches TIMEOUT: timeout_err=1 (sticky until next start/newImage), converged=0, go to STOP.
- Undefined: no counter is built; timeout_err is tied to 0.

Test Plan:
- Header {N=8,K=3}, then 8 pixels, no stalls → eng_en sequence 1,2,4,8,1,2,4,8; eng_addr 0,0,0,0,1,1,1,1; k_mask=16'h0007; LOADED after 9 accepts.
- Header K=0, then header K=17 → hdr_err=1 each time, state IDLE, in_ready=0.
- start, eng_done bits arriving on different cycles, div_done after 5 cycles, all_mean_stable=1 → exactly one eng_clr/eng_run/div_start/mean_update pulse; done=1, converged=1, iter_cnt=1.
- all_mean_stable held 0, MAX_ITER=4 → 4 full iterations, done=1, converged=0, iter_cnt=4.
- reset=0 for 1 cycle during WAIT_ENG → all outputs 0, IDLE; a later start is ignored until an image is loaded.
- With KMEANS_WATCHDOG_TIMEOUT_EN and TIMEOUT=20, one engine never pulses eng_done → timeout_err=1 and done=1 exactly 20 cycles after WAIT_ENG entry.
